// File: rtl/inc_pulse_gen.sv
// rtl/inc_pulse_gen.sv - burst generator of single-cycle counter increment pulses
//
// Purpose:
//   Emits a programmed burst of one-cycle increment pulses for a downstream
//   event counter. Burst length and inter-pulse gap are latched when start
//   is accepted in IDLE. A start/busy/done handshake is provided, and a
//   running burst can be cancelled with abort.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   resetn     in   1      asynchronous active-low reset
//   start      in   1      request a burst; sampled only in IDLE
//   abort      in   1      synchronous cancel of a running burst
//   burst_len  in   LEN_W  pulses to emit; latched when start is accepted
//   gap        in   GAP_W  low cycles between pulses; latched with burst_len
//   inc_pulse  out  1      one-cycle increment pulse (registered)
//   busy       out  1      high while in PULSE or GAP (registered)
//   done       out  1      one-cycle strobe at burst completion (registered)
//   remaining  out  LEN_W  pulses not yet emitted

module inc_pulse_gen #(
   parameter int LEN_W = 16,
   parameter int GAP_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] burst_len,
   input  logic [GAP_W-1:0] gap,
   output logic             inc_pulse,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] remaining
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   state_t           state, state_nxt;
   logic [GAP_W-1:0] gap_lat, gap_lat_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
   logic [LEN_W-1:0] rem_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         gap_lat   <= '0;
         gap_cnt   <= '0;
         remaining <= '0;
         inc_pulse <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         gap_lat   <= gap_lat_nxt;
         gap_cnt   <= gap_cnt_nxt;
         remaining <= rem_nxt;
         // Outputs are decoded from the next state so they line up with
         // the state they describe while still coming straight from flops.
         inc_pulse <= (state_nxt == S_PULSE);
         busy      <= (state_nxt == S_PULSE) || (state_nxt == S_GAP);
         done      <= (state_nxt == S_DONE);
      end
   end

   always_comb begin
      state_nxt   = state;
      gap_lat_nxt = gap_lat;
      gap_cnt_nxt = gap_cnt;
      rem_nxt     = remaining;

      case (state)
         S_IDLE: begin
            if (start) begin
               gap_lat_nxt = gap;
               rem_nxt     = burst_len;
               state_nxt   = (burst_len != '0) ? S_PULSE : S_DONE;
            end
         end

         S_PULSE: begin
            // The pulse of this cycle has been emitted, so remaining drops
            // even when the burst is aborted; guarded so it can never wrap.
            if (remaining != '0) begin
               rem_nxt = remaining - LEN_ONE;
            end
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (remaining <= LEN_ONE) begin
               state_nxt = S_DONE;
            end else if (gap_lat == '0) begin
               state_nxt = S_PULSE;
            end else begin
               state_nxt   = S_GAP;
               gap_cnt_nxt = gap_lat;
            end
         end

         S_GAP: begin
            // gap_cnt counts gap_lat..1, giving exactly gap_lat idle cycles.
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (gap_cnt <= GAP_ONE) begin
               state_nxt   = S_PULSE;
               gap_cnt_nxt = '0;
            end else begin
               gap_cnt_nxt = gap_cnt - GAP_ONE;
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
            rem_nxt   = '0;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_inc_pulse_gen.sv
// tb/tb_inc_pulse_gen.sv - self-checking bench for inc_pulse_gen

module tb_inc_pulse_gen;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        abort;
   logic [15:0] burst_len;
   logic [7:0]  gap;
   logic        inc_pulse;
   logic        busy;
   logic        done;
   logic [15:0] remaining;

   int n_vec  = 0;
   int n_miss = 0;

   inc_pulse_gen #(.LEN_W(16), .GAP_W(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .abort     (abort),
      .burst_len (burst_len),
      .gap       (gap),
      .inc_pulse (inc_pulse),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        ab;
      logic [15:0] len;
      logic [7:0]  gp;
      logic        e_inc;
      logic        e_busy;
      logic        e_done;
      logic [15:0] e_rem;
   } vec_t;

   vec_t tbl[19];

   function automatic vec_t r(logic st, logic ab, logic [15:0] len, logic [7:0] gp,
                              logic ei, logic eb, logic ed, logic [15:0] er);
      vec_t v;
      v.st = st; v.ab = ab; v.len = len; v.gp = gp;
      v.e_inc = ei; v.e_busy = eb; v.e_done = ed; v.e_rem = er;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] cnt3;

   initial begin
      // Row i: outputs expected in cycle i, then inputs driven during cycle i.
      // Rows 0-8: N=3 gap=2 (len/gap wiggled mid-burst, start ignored while busy,
      // abort ignored in DONE). Rows 9-10: N=0. Rows 11-16: N=4 gap=0.
      tbl[0]  = r(1, 0, 3, 2, 0, 0, 0, 0);
      tbl[1]  = r(0, 0, 7, 0, 1, 1, 0, 3);
      tbl[2]  = r(1, 0, 9, 4, 0, 1, 0, 2);
      tbl[3]  = r(0, 0, 0, 0, 0, 1, 0, 2);
      tbl[4]  = r(0, 0, 0, 0, 1, 1, 0, 2);
      tbl[5]  = r(0, 0, 0, 0, 0, 1, 0, 1);
      tbl[6]  = r(0, 0, 0, 0, 0, 1, 0, 1);
      tbl[7]  = r(0, 0, 0, 0, 1, 1, 0, 1);
      tbl[8]  = r(0, 1, 0, 0, 0, 0, 1, 0);
      tbl[9]  = r(1, 0, 0, 3, 0, 0, 0, 0);
      tbl[10] = r(0, 0, 0, 0, 0, 0, 1, 0);
      tbl[11] = r(1, 0, 4, 0, 0, 0, 0, 0);
      tbl[12] = r(0, 0, 0, 0, 1, 1, 0, 4);
      tbl[13] = r(0, 0, 0, 0, 1, 1, 0, 3);
      tbl[14] = r(0, 0, 0, 0, 1, 1, 0, 2);
      tbl[15] = r(0, 0, 0, 0, 1, 1, 0, 1);
      tbl[16] = r(0, 0, 0, 0, 0, 0, 1, 0);
      tbl[17] = r(0, 1, 0, 0, 0, 0, 0, 0);
      tbl[18] = r(0, 0, 0, 0, 0, 0, 0, 0);

      resetn = 1'b0; start = 1'b0; abort = 1'b0; burst_len = '0; gap = '0;
      cnt3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_inc",  0, 32'(inc_pulse), 0);
      chk("rst_busy", 0, 32'(busy),      0);
      chk("rst_done", 0, 32'(done),      0);
      chk("rst_rem",  0, 32'(remaining), 0);
      resetn = 1'b1;
      step();

      // ---------------- table-driven section ----------------
      for (int i = 0; i < 19; i++) begin
         chk("tbl_inc",  i, 32'(inc_pulse), 32'(tbl[i].e_inc));
         chk("tbl_busy", i, 32'(busy),      32'(tbl[i].e_busy));
         chk("tbl_done", i, 32'(done),      32'(tbl[i].e_done));
         chk("tbl_rem",  i, 32'(remaining), 32'(tbl[i].e_rem));
         if (i >= 11 && inc_pulse) cnt3 = cnt3 + 16'd1;
         start = tbl[i].st; abort = tbl[i].ab; burst_len = tbl[i].len; gap = tbl[i].gp;
         step();
      end
      chk("counter_n4", 0, 32'(cnt3), 4);

      // ---------------- busy rejection: N=2 gap=5 ----------------
      start = 1'b1; burst_len = 16'd2; gap = 8'd5;
      for (int c = 1; c <= 12; c++) begin
         step();
         chk("rej_inc",  c, 32'(inc_pulse), 32'((c == 1) || (c == 7) || (c == 10)));
         chk("rej_done", c, 32'(done),      32'((c == 8) || (c == 11)));
         start     = (c == 3) || (c == 8) || (c == 9);
         burst_len = (c == 3) ? 16'd9 : 16'd1;
         gap       = 8'd0;
      end
      start = 1'b0;

      // ---------------- abort: N=10 gap=1, abort in cycle 6 ----------------
      start = 1'b1; burst_len = 16'd10; gap = 8'd1;
      for (int c = 1; c <= 12; c++) begin
         step();
         chk("abt_inc",  c, 32'(inc_pulse), 32'((c == 1) || (c == 3) || (c == 5)));
         chk("abt_done", c, 32'(done),      0);
         if (c >= 7) begin
            chk("abt_busy", c, 32'(busy),      0);
            chk("abt_rem",  c, 32'(remaining), 7);
         end
         abort = (c == 6);
         start = (c == 6);
      end
      abort = 1'b0; start = 1'b0;

      // ---------------- async reset mid-burst: N=5 gap=3 ----------------
      start = 1'b1; burst_len = 16'd5; gap = 8'd3;
      for (int c = 1; c <= 6; c++) begin
         step();
         start = 1'b0;
         chk("rmb_inc", c, 32'(inc_pulse), 32'((c == 1) || (c == 5)));
      end
      chk("rmb_busy", 6, 32'(busy),      1);
      chk("rmb_rem",  6, 32'(remaining), 3);
      #2 resetn = 1'b0;
      #1;
      chk("rmb_async_inc",  0, 32'(inc_pulse), 0);
      chk("rmb_async_busy", 0, 32'(busy),      0);
      chk("rmb_async_done", 0, 32'(done),      0);
      chk("rmb_async_rem",  0, 32'(remaining), 0);
      step();
      chk("rmb_held_inc", 0, 32'(inc_pulse), 0);
      resetn = 1'b1;
      step();
      start = 1'b1; burst_len = 16'd1; gap = 8'd0;
      step();
      start = 1'b0;
      chk("post_inc",  1, 32'(inc_pulse), 1);
      chk("post_busy", 1, 32'(busy),      1);
      chk("post_rem",  1, 32'(remaining), 1);
      step();
      chk("post_inc",  2, 32'(inc_pulse), 0);
      chk("post_done", 2, 32'(done),      1);
      chk("post_rem",  2, 32'(remaining), 0);
      step();
      chk("post_done", 3, 32'(done),      0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
